// File: rtl/fsab_arbiter_input_fifo.sv
// FSAB arbiter per-requester input FIFO.
// Buffers whole request transactions and replays one per grant.
module fsab_arbiter_input_fifo #(
  parameter int REQ_HI  = 0,
  parameter int DID_HI  = 3,
  parameter int ADDR_HI = 30,
  parameter int LEN_HI  = 2,
  parameter int DATA_HI = 63,
  parameter int MASK_HI = 7,
  parameter int DEPTH   = 32
) (
  input  logic           clk,
  input  logic           Nrst,
  input  logic           inp_valid,
  input  logic [REQ_HI:0]  inp_mode,
  input  logic [DID_HI:0]  inp_did,
  input  logic [DID_HI:0]  inp_subdid,
  input  logic [ADDR_HI:0] inp_addr,
  input  logic [LEN_HI:0]  inp_len,
  input  logic [DATA_HI:0] inp_data,
  input  logic [MASK_HI:0] inp_mask,
  output logic           inp_credit,
  input  logic           start,
  output logic           empty_b,
  output logic           active,
  output logic           out_valid,
  output logic [REQ_HI:0]  out_mode,
  output logic [DID_HI:0]  out_did,
  output logic [DID_HI:0]  out_subdid,
  output logic [ADDR_HI:0] out_addr,
  output logic [LEN_HI:0]  out_len,
  output logic [DATA_HI:0] out_data,
  output logic [MASK_HI:0] out_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = LEN_HI + 1;
  localparam int RW = REQ_HI + 1;
  localparam int CW = PW + 1;

  logic [REQ_HI:0]  mem_mode   [DEPTH];
  logic [DID_HI:0]  mem_did    [DEPTH];
  logic [DID_HI:0]  mem_subdid [DEPTH];
  logic [ADDR_HI:0] mem_addr   [DEPTH];
  logic [LEN_HI:0]  mem_len    [DEPTH];
  logic [DATA_HI:0] mem_data   [DEPTH];
  logic [MASK_HI:0] mem_mask   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] in_rem_q, in_rem_d;
  logic [LW-1:0] out_rem_q, out_rem_d;
  logic [CW-1:0] txn_cnt_q, txn_cnt_d;
  logic          active_q, active_d;
  logic          credit_q, credit_d;
  logic          empty_b_q, empty_b_d;

  logic          in_done;
  logic          dispatch;
  logic [LW-1:0] in_beats;
  logic [LW-1:0] rd_beats;

  function automatic logic [LW-1:0] beats_of(
    input logic [REQ_HI:0] m,
    input logic [LW-1:0]   l
  );
    if (m != RW'(1)) return LW'(1);
    if (l == '0) return LW'(1);
    return l;
  endfunction

  assign out_mode   = mem_mode[rd_ptr_q];
  assign out_did    = mem_did[rd_ptr_q];
  assign out_subdid = mem_subdid[rd_ptr_q];
  assign out_addr   = mem_addr[rd_ptr_q];
  assign out_len    = mem_len[rd_ptr_q];
  assign out_data   = mem_data[rd_ptr_q];
  assign out_mask   = mem_mask[rd_ptr_q];

  assign out_valid  = active_q;
  assign active     = active_q;
  assign inp_credit = credit_q;
  assign empty_b    = empty_b_q;

  assign in_beats = beats_of(inp_mode, inp_len);
  assign rd_beats = beats_of(out_mode, out_len);
  assign dispatch = start && !active_q && (txn_cnt_q != '0);

  // Beat storage; contents are not reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (inp_valid) begin
      mem_mode[wr_ptr_q]   <= inp_mode;
      mem_did[wr_ptr_q]    <= inp_did;
      mem_subdid[wr_ptr_q] <= inp_subdid;
      mem_addr[wr_ptr_q]   <= inp_addr;
      mem_len[wr_ptr_q]    <= inp_len;
      mem_data[wr_ptr_q]   <= inp_data;
      mem_mask[wr_ptr_q]   <= inp_mask;
    end
  end

  // Input side: count down beats of the incoming transaction.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    in_rem_d = in_rem_q;
    in_done  = 1'b0;
    if (inp_valid) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (in_rem_q == '0) begin
        in_done  = (in_beats == LW'(1));
        in_rem_d = in_beats - LW'(1);
      end else begin
        in_done  = (in_rem_q == LW'(1));
        in_rem_d = in_rem_q - LW'(1);
      end
    end
  end

  // Output side: grant handling, replay and credit return.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    out_rem_d = out_rem_q;
    active_d  = active_q;
    credit_d  = 1'b0;
    unique case (1'b1)
      dispatch: begin
        active_d  = 1'b1;
        out_rem_d = rd_beats;
      end
      active_q: begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        out_rem_d = out_rem_q - LW'(1);
        if (out_rem_q == LW'(1)) begin
          active_d = 1'b0;
          credit_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Ready-transaction count; completion and dispatch cancel out.
  always_comb begin
    txn_cnt_d = txn_cnt_q;
    unique case ({in_done, dispatch})
      2'b10:   txn_cnt_d = txn_cnt_q + CW'(1);
      2'b01:   txn_cnt_d = txn_cnt_q - CW'(1);
      default: txn_cnt_d = txn_cnt_q;
    endcase
    empty_b_d = (txn_cnt_d != '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      in_rem_q  <= '0;
      out_rem_q <= '0;
      txn_cnt_q <= '0;
      active_q  <= 1'b0;
      credit_q  <= 1'b0;
      empty_b_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      in_rem_q  <= in_rem_d;
      out_rem_q <= out_rem_d;
      txn_cnt_q <= txn_cnt_d;
      active_q  <= active_d;
      credit_q  <= credit_d;
      empty_b_q <= empty_b_d;
    end
  end

endmodule

// File: tb/tb_fsab_arbiter_input_fifo.sv
// Bench for fsab_arbiter_input_fifo.
// Scoreboard of expected beats plus a transaction-level timing model.
module tb_fsab_arbiter_input_fifo;

  typedef struct packed {
    logic [0:0]  mode;
    logic [3:0]  did;
    logic [3:0]  subdid;
    logic [30:0] addr;
    logic [2:0]  len;
    logic [63:0] data;
    logic [7:0]  mask;
  } beat_t;

  logic        clk;
  logic        Nrst;
  logic        inp_valid;
  logic [0:0]  inp_mode;
  logic [3:0]  inp_did;
  logic [3:0]  inp_subdid;
  logic [30:0] inp_addr;
  logic [2:0]  inp_len;
  logic [63:0] inp_data;
  logic [7:0]  inp_mask;
  logic        inp_credit;
  logic        start;
  logic        empty_b;
  logic        active;
  logic        out_valid;
  logic [0:0]  out_mode;
  logic [3:0]  out_did;
  logic [3:0]  out_subdid;
  logic [30:0] out_addr;
  logic [2:0]  out_len;
  logic [63:0] out_data;
  logic [7:0]  out_mask;

  logic  drv_last;
  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    m_lens[$];
  int    m_ready = 0;
  int    m_busy = 0;
  bit    m_credit = 0;
  bit    m_disp;
  int    sent = 0;
  int    credits_rx = 0;
  bit    dev_done;

  fsab_arbiter_input_fifo dut (
    .clk(clk), .Nrst(Nrst),
    .inp_valid(inp_valid), .inp_mode(inp_mode),
    .inp_did(inp_did), .inp_subdid(inp_subdid),
    .inp_addr(inp_addr), .inp_len(inp_len),
    .inp_data(inp_data), .inp_mask(inp_mask),
    .inp_credit(inp_credit), .start(start),
    .empty_b(empty_b), .active(active),
    .out_valid(out_valid), .out_mode(out_mode),
    .out_did(out_did), .out_subdid(out_subdid),
    .out_addr(out_addr), .out_len(out_len),
    .out_data(out_data), .out_mask(out_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: ready count and remaining grant cycles per transaction.
  always @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      m_ready = 0;
      m_busy = 0;
      m_credit = 0;
      exp_q.delete();
      m_lens.delete();
    end else begin
      m_disp = start && (m_busy == 0) && (m_ready > 0);
      m_credit = 0;
      if (m_disp) begin
        m_busy = m_lens.pop_front();
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_credit = 1;
      end
      m_ready = m_ready + ((inp_valid && drv_last) ? 1 : 0)
                - (m_disp ? 1 : 0);
    end
  end

  // Monitor: compare flags against the model and beats against the queue.
  always @(negedge clk) begin
    beat_t eb;
    if (!Nrst) begin
      chk("rst_active", 128'(active), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_empty_b", 128'(empty_b), 128'(0));
      chk("rst_credit", 128'(inp_credit), 128'(0));
    end else begin
      chk("active", 128'(active), 128'(m_busy > 0));
      chk("out_valid", 128'(out_valid), 128'(m_busy > 0));
      chk("empty_b", 128'(empty_b), 128'(m_ready > 0));
      chk("inp_credit", 128'(inp_credit), 128'(m_credit));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat: out_valid with no beat expected");
        end else begin
          eb = exp_q.pop_front();
          chk("beat",
              128'({out_mode, out_did, out_subdid, out_addr,
                    out_len, out_data, out_mask}),
              128'(eb));
        end
      end
      if (inp_credit) credits_rx++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic send_txn(input logic [0:0]  mode,
                          input logic [3:0]  did,
                          input logic [30:0] addr,
                          input logic [2:0]  len,
                          input bit          seq,
                          input logic [63:0] dbase,
                          input bit          gaps);
    int n;
    int w;
    n = (mode == 1'b1) ? ((len == 3'd0) ? 1 : int'(len)) : 1;
    w = 0;
    while ((sent - credits_rx) >= 4 && w < 2000) begin
      cyc(1);
      w++;
    end
    checks++;
    if (w >= 2000) begin
      errors++;
      $display("FAIL credit_wait: waited %0d cycles, need a credit", w);
    end
    m_lens.push_back(n);
    sent++;
    for (int b = 0; b < n; b++) begin
      beat_t bt;
      bt.mode   = mode;
      bt.did    = did;
      bt.subdid = 4'($urandom);
      bt.addr   = addr;
      bt.len    = len;
      bt.data   = seq ? dbase + 64'(b) : {$urandom, $urandom};
      bt.mask   = 8'($urandom);
      {inp_mode, inp_did, inp_subdid, inp_addr,
       inp_len, inp_data, inp_mask} = bt;
      inp_valid = 1'b1;
      drv_last  = (b == n - 1);
      exp_q.push_back(bt);
      cyc(1);
      inp_valid = 1'b0;
      drv_last  = 1'b0;
      if (gaps) cyc($urandom_range(0, 1));
    end
  endtask

  initial begin
    int w;
    inp_valid = 0; inp_mode = '0; inp_did = '0; inp_subdid = '0;
    inp_addr = '0; inp_len = '0; inp_data = '0; inp_mask = '0;
    start = 0; drv_last = 0;
    Nrst = 1'b1;
    #2 Nrst = 1'b0;
    cyc(3);
    Nrst = 1'b1;

    // Start with nothing buffered is ignored.
    pulse_start();
    cyc(2);

    // Single read.
    send_txn(1'b0, 4'd2, 31'h100, 3'd3, 1'b0, 64'h0, 1'b0);
    cyc(1);
    pulse_start();
    cyc(4);

    // Four-beat write with sequential data.
    send_txn(1'b1, 4'd5, 31'h200, 3'd4, 1'b1, 64'hA0, 1'b0);
    pulse_start();
    cyc(6);

    // Two reads, start held high.
    send_txn(1'b0, 4'd1, 31'h111, 3'd0, 1'b0, 64'h0, 1'b0);
    send_txn(1'b0, 4'd7, 31'h222, 3'd6, 1'b0, 64'h0, 1'b0);
    start = 1'b1;
    cyc(8);
    start = 1'b0;
    cyc(2);

    // Enqueue during replay.
    send_txn(1'b1, 4'd3, 31'h300, 3'd5, 1'b0, 64'h0, 1'b0);
    fork
      pulse_start();
      begin
        cyc(1);
        send_txn(1'b1, 4'd4, 31'h400, 3'd7, 1'b0, 64'h0, 1'b1);
      end
    join
    cyc(8);
    pulse_start();
    cyc(10);

    // Reset during a write replay.
    send_txn(1'b1, 4'd6, 31'h500, 3'd6, 1'b1, 64'h50, 1'b0);
    pulse_start();
    cyc(2);
    Nrst = 1'b0;
    #1;
    chk("mid_rst_active", 128'(active), 128'(0));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_empty_b", 128'(empty_b), 128'(0));
    sent = 0;
    credits_rx = 0;
    cyc(1);
    Nrst = 1'b1;
    start = 1'b1;
    cyc(4);
    start = 1'b0;

    // Random traffic with a random arbiter.
    dev_done = 0;
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          send_txn(1'($urandom_range(0, 1)), 4'($urandom),
                   31'($urandom), 3'($urandom), 1'b0, 64'h0, 1'b1);
          cyc($urandom_range(0, 2));
        end
        dev_done = 1;
      end
      begin
        w = 0;
        while (!(dev_done && m_ready == 0 && m_busy == 0) && w < 20000) begin
          start = dev_done ? 1'b1 : ($urandom_range(0, 2) == 0);
          cyc(1);
          w++;
        end
        start = 1'b0;
        checks++;
        if (w >= 20000) begin
          errors++;
          $display("FAIL drain: not drained after %0d cycles", w);
        end
      end
    join
    cyc(3);

    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    chk("credits_total", 128'(credits_rx), 128'(sent));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
